// File: rtl/clk_gen_pkg.sv
// Shared definitions for the clock-phase generator.
//   state_e   : sequencer states (IDLE, ALIGN, RUN, DRAIN)
//   DIV_W_DEF : default width of the half-period divide value
package clk_gen_pkg;

  localparam int unsigned DIV_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    ALIGN,
    RUN,
    DRAIN
  } state_e;

endpackage

// File: rtl/clk_phase_channel.sv
// One derived clock channel: div/phase registers, a single pending update
// slot, the period counter and the registered clk/tick outputs.
// Ports:
//   clk_i, rst_i     master clock, asynchronous active-high reset
//   mode_i           sequencer state driving this channel
//   wr_i             immediate configuration write (IDLE only)
//   stage_i          staged configuration write (RUN only)
//   div_i, phase_i   configuration payload
//   clk_o, tick_o    registered derived clock and rise pulse
//   wrap_o           period boundary this cycle (always true while disabled)
//   stopped_o        channel has finished draining or is disabled
//   pend_o           an update is staged and not yet applied
module clk_phase_channel
  import clk_gen_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  state_e           mode_i,
  input  logic             wr_i,
  input  logic             stage_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic [DIV_W:0]   phase_i,
  output logic             clk_o,
  output logic             tick_o,
  output logic             wrap_o,
  output logic             stopped_o,
  output logic             pend_o
);

  localparam int unsigned CW = DIV_W + 1;

  logic [DIV_W-1:0] div_q, div_d, pdiv_q, pdiv_d;
  logic [CW-1:0]    phase_q, phase_d, cnt_q, cnt_d, last;
  logic             pend_q, pend_d, stop_q, stop_d;
  logic             clk_q, clk_d, tick_q, tick_d;
  logic             active, drain, apply;

  assign last      = {div_q, 1'b0} - CW'(1);
  assign active    = ((mode_i == RUN) || (mode_i == DRAIN)) && !stop_q;
  assign drain     = (mode_i == DRAIN);
  // A disabled channel sits permanently on a boundary, so a staged update
  // for it lands on the very next cycle.
  assign wrap_o    = active && ((div_q == '0) || (cnt_q == last));
  assign apply     = pend_q && wrap_o;
  assign stopped_o = stop_q || ((div_q == '0) && !pend_q);
  assign pend_o    = pend_q;
  assign clk_o     = clk_q;
  assign tick_o    = tick_q;

  always_comb begin
    div_d   = div_q;
    pdiv_d  = pdiv_q;
    phase_d = phase_q;
    pend_d  = pend_q;
    stop_d  = stop_q;
    cnt_d   = cnt_q;
    clk_d   = 1'b0;
    tick_d  = 1'b0;
    unique case (mode_i)
      IDLE: begin
        cnt_d  = '0;
        stop_d = 1'b0;
        if (wr_i) begin
          div_d   = div_i;
          phase_d = phase_i;
        end
      end
      ALIGN: begin
        stop_d = 1'b0;
        cnt_d  = (phase_q < {div_q, 1'b0}) ? phase_q : '0;
        clk_d  = cnt_d < {1'b0, div_q};
      end
      default: begin
        if (active) begin
          if (apply) begin
            div_d  = pdiv_q;
            pend_d = 1'b0;
            cnt_d  = '0;
            if (drain) begin
              stop_d = 1'b1;
            end else begin
              clk_d  = (pdiv_q != '0);
              tick_d = clk_d;
            end
          end else if (div_q == '0) begin
            cnt_d = '0;
          end else if (wrap_o) begin
            cnt_d = '0;
            if (drain) begin
              stop_d = 1'b1;
            end else begin
              clk_d  = 1'b1;
              tick_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
            clk_d = cnt_d < {1'b0, div_q};
          end
        end
        if (stage_i) begin
          pdiv_d  = div_i;
          phase_d = phase_i;
          pend_d  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_q   <= '0;
      pdiv_q  <= '0;
      phase_q <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      stop_q  <= 1'b0;
      clk_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      div_q   <= div_d;
      pdiv_q  <= pdiv_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      stop_q  <= stop_d;
      clk_q   <= clk_d;
      tick_q  <= tick_d;
    end
  end

endmodule

// File: rtl/clk_phase_gen.sv
// Multi-channel clock-phase generator: sequencer FSM, configuration demux
// and handshake, plus NUM_CH clk_phase_channel instances.
// Ports:
//   clock, reset          master clock, asynchronous active-high reset
//   enable                run request (level)
//   cfg_valid/cfg_ready   configuration handshake
//   cfg_ch/div/phase      target channel, half-period (0 = off), start count
//   clk_out, tick         registered derived clocks and rise pulses
//   locked                running with no update pending
module clk_phase_gen
  import clk_gen_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DIV_W  = DIV_W_DEF
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
  input  logic [DIV_W-1:0]          cfg_div,
  input  logic [DIV_W:0]            cfg_phase,
  output logic [NUM_CH-1:0]         clk_out,
  output logic [NUM_CH-1:0]         tick,
  output logic                      locked
);

  localparam int unsigned CH_W = $clog2(NUM_CH);

  state_e              state_q, state_d;
  logic                armed_q, rdy_q, lock_q;
  logic                accept, pend_any_q, pend_any_d, quiet;
  logic [NUM_CH-1:0]   pend_v, wrap_v, stop_v;

  assign accept     = cfg_valid && rdy_q;
  assign pend_any_q = |pend_v;
  assign pend_any_d = (|(pend_v & ~wrap_v)) || (accept && (state_q == RUN));
  // Handshake reopens only after a full cycle with nothing pending, so the
  // new divide is already in effect when the next write can land.
  assign quiet      = !pend_any_q && !pend_any_d;
  assign cfg_ready  = rdy_q;
  assign locked     = lock_q;

  always_comb begin
    state_d = state_q;
    // armed_q delays the first transition to the second edge after release.
    if (armed_q) begin
      unique case (state_q)
        IDLE:    if (enable) state_d = ALIGN;
        ALIGN:   state_d = RUN;
        RUN:     if (!enable) state_d = DRAIN;
        DRAIN:   if (&stop_v) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      armed_q <= 1'b0;
      rdy_q   <= 1'b1;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= 1'b1;
      rdy_q   <= (state_d == IDLE) || ((state_d == RUN) && quiet);
      lock_q  <= (state_d == RUN) && quiet;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic hit;
    assign hit = accept && (cfg_ch == CH_W'(i));

    clk_phase_channel #(
      .DIV_W(DIV_W)
    ) u_ch (
      .clk_i    (clock),
      .rst_i    (reset),
      .mode_i   (state_q),
      .wr_i     (hit && (state_q == IDLE)),
      .stage_i  (hit && (state_q == RUN)),
      .div_i    (cfg_div),
      .phase_i  (cfg_phase),
      .clk_o    (clk_out[i]),
      .tick_o   (tick[i]),
      .wrap_o   (wrap_v[i]),
      .stopped_o(stop_v[i]),
      .pend_o   (pend_v[i])
    );
  end

endmodule

// File: tb/tb_clk_phase_gen.sv
module tb_clk_phase_gen;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned DIV_W  = 4;
  localparam int unsigned CH_W   = 2;

  localparam int M_IDLE  = 0;
  localparam int M_ALIGN = 1;
  localparam int M_RUN   = 2;
  localparam int M_DRAIN = 3;

  logic              clock = 1'b0;
  logic              reset;
  logic              enable;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch;
  logic [DIV_W-1:0]  cfg_div;
  logic [DIV_W:0]    cfg_phase;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;
  logic              locked;

  int n_cmp = 0;
  int n_err = 0;

  clk_phase_gen #(
    .NUM_CH(NUM_CH),
    .DIV_W (DIV_W)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .cfg_phase(cfg_phase),
    .clk_out  (clk_out),
    .tick     (tick),
    .locked   (locked)
  );

  always #5 clock = ~clock;

  // Reference model: each running channel is described by the cycle at
  // which its position was 0 (base); its waveform at cycle t follows from
  // (t - base) mod 2*div.
  int cyc;
  int mst;
  bit armed;
  bit pend_prev;
  int md   [NUM_CH];
  int mp   [NUM_CH];
  int mpd  [NUM_CH];
  bit mpend[NUM_CH];
  bit mstop[NUM_CH];
  int mbase[NUM_CH];
  int mld  [NUM_CH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mst = M_IDLE;
    armed = 1'b0;
    pend_prev = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      md[i] = 0; mp[i] = 0; mpd[i] = 0; mpend[i] = 1'b0;
      mstop[i] = 1'b0; mbase[i] = 0; mld[i] = 0;
    end
  endtask

  function automatic bit any_pend();
    bit r = 1'b0;
    for (int i = 0; i < NUM_CH; i++) r |= mpend[i];
    return r;
  endfunction

  task automatic model_edge();
    int pre, t, c;
    bit pany, pre_ready, all_stop, bound;
    cyc++;
    t = cyc;
    if (reset) begin
      model_reset();
      return;
    end
    pre = mst;
    pany = any_pend();
    all_stop = 1'b1;
    for (int i = 0; i < NUM_CH; i++)
      if (!(mstop[i] || (md[i] == 0 && !mpend[i]))) all_stop = 1'b0;
    pre_ready = (pre == M_IDLE) || (pre == M_RUN && !pany && !pend_prev);

    for (int i = 0; i < NUM_CH; i++) begin
      if (pre == M_IDLE) begin
        mstop[i] = 1'b0;
      end else if (pre == M_ALIGN) begin
        c = (mp[i] < 2 * md[i]) ? mp[i] : 0;
        mbase[i] = t - c;
        mld[i] = t;
        mstop[i] = 1'b0;
      end else if (!mstop[i]) begin
        bound = 1'b1;
        if (md[i] != 0) bound = ((t - mbase[i]) % (2 * md[i])) == 0;
        if (mpend[i] && bound) begin
          md[i] = mpd[i];
          mpend[i] = 1'b0;
          mbase[i] = t;
          mld[i] = -1;
          if (pre == M_DRAIN) mstop[i] = 1'b1;
        end else if (md[i] != 0 && bound && pre == M_DRAIN) begin
          mstop[i] = 1'b1;
        end
      end
    end

    if (cfg_valid && pre_ready) begin
      if (pre == M_IDLE) begin
        md[int'(cfg_ch)] = int'(cfg_div);
        mp[int'(cfg_ch)] = int'(cfg_phase);
      end else begin
        mpd[int'(cfg_ch)] = int'(cfg_div);
        mp[int'(cfg_ch)] = int'(cfg_phase);
        mpend[int'(cfg_ch)] = 1'b1;
      end
    end

    if (!armed) begin
      armed = 1'b1;
    end else begin
      case (pre)
        M_IDLE:  if (enable) mst = M_ALIGN;
        M_ALIGN: mst = M_RUN;
        M_RUN:   if (!enable) mst = M_DRAIN;
        default: if (all_stop) mst = M_IDLE;
      endcase
    end
    pend_prev = pany;
  endtask

  task automatic check_cycle();
    logic [NUM_CH-1:0] ec, et;
    logic er, el;
    int pos;
    bit quiet;
    ec = '0;
    et = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if ((mst == M_RUN || mst == M_DRAIN) && !mstop[i] && md[i] != 0) begin
        pos = (cyc - mbase[i]) % (2 * md[i]);
        ec[i] = (pos < md[i]);
        et[i] = (pos == 0) && (cyc != mld[i]);
      end
    end
    quiet = !any_pend() && !pend_prev;
    er = (mst == M_IDLE) || (mst == M_RUN && quiet);
    el = (mst == M_RUN) && quiet;
    chk("clk_out", 32'(clk_out), 32'(ec));
    chk("tick", 32'(tick), 32'(et));
    chk("cfg_ready", 32'(cfg_ready), 32'(er));
    chk("locked", 32'(locked), 32'(el));
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check_cycle();
  endtask

  task automatic cfg_write(input int ch, input int dv, input int ph);
    cfg_valid = 1'b1;
    cfg_ch    = CH_W'(ch);
    cfg_div   = DIV_W'(dv);
    cfg_phase = (DIV_W + 1)'(ph);
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic rand_inputs();
    if ($urandom_range(0, 39) == 0) enable = ~enable;
    cfg_valid = ($urandom_range(0, 5) == 0);
    cfg_ch    = CH_W'($urandom_range(0, NUM_CH - 1));
    cfg_div   = ($urandom_range(0, 9) == 0) ? DIV_W'(15) : DIV_W'($urandom_range(0, 5));
    cfg_phase = (DIV_W + 1)'($urandom_range(0, 31));
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; cfg_valid = 1'b0;
    cfg_ch = '0; cfg_div = '0; cfg_phase = '0;
    cyc = 0;
    model_reset();
    step();
    step();
    reset = 1'b0;

    // Basic waveforms
    cfg_write(0, 1, 0);
    cfg_write(1, 2, 0);
    cfg_write(2, 3, 0);
    cfg_write(3, 0, 0);
    enable = 1'b1;
    repeat (30) step();

    // Run-time update of ch1, then a disabled channel brought up live
    cfg_write(1, 3, 0);
    repeat (12) step();
    cfg_write(3, 2, 1);
    repeat (12) step();

    // Drain with enable re-raised while draining
    enable = 1'b0;
    step();
    enable = 1'b1;
    repeat (2) step();
    enable = 1'b0;
    repeat (40) step();

    // Phase offset, then clamped phase
    cfg_write(0, 2, 0);
    cfg_write(1, 2, 2);
    cfg_write(2, 0, 0);
    cfg_write(3, 0, 0);
    enable = 1'b1;
    repeat (20) step();
    enable = 1'b0;
    repeat (20) step();
    cfg_write(1, 2, 5);
    enable = 1'b1;
    repeat (20) step();
    // Handshake coinciding with enable falling
    enable = 1'b0;
    cfg_write(0, 3, 0);
    repeat (30) step();

    // Randomised traffic
    repeat (2500) begin
      rand_inputs();
      step();
    end

    // Asynchronous reset between edges while running
    cfg_valid = 1'b0;
    enable = 1'b1;
    repeat (10) step();
    #2 reset = 1'b1;
    #1;
    chk("rst_clk_out", 32'(clk_out), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    model_reset();
    step();
    reset = 1'b0;
    enable = 1'b1;
    repeat (20) step();
    enable = 1'b0;
    repeat (5) step();

    repeat (1500) begin
      rand_inputs();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
